// File: rtl/fml_pkg.sv
// Shared FML burst constants, responder FSM state encoding and port identifiers.
package fml_pkg;

    localparam int FML_BURST_LEN = 4;
    localparam int FML_BEAT_BITS = 2;
    localparam int FML_DW        = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACK   = 2'd1,
        ST_BURST = 2'd2
    } fml_state_e;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LCD = 1'b1;

endpackage

// File: rtl/vram_spram.sv
// Single-port synchronous video RAM with per-byte write enables and a registered read port.
module vram_spram
    import fml_pkg::*;
#(
    parameter int AW = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic                we_i,
    input  logic [FML_DW/8-1:0] be_i,
    input  logic [AW-1:0]       addr_i,
    input  logic [FML_DW-1:0]   wdata_i,
    output logic [FML_DW-1:0]   rdata_o
);

    logic [FML_DW-1:0] mem_q [2**AW];
    logic [FML_DW-1:0] rdata_q;

    // Storage has no reset so the picture survives a controller reset.
    always_ff @(posedge clk_i) begin
        if (en_i && we_i) begin
            for (int b = 0; b < FML_DW/8; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (en_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fml_vram_slave.sv
// FML burst responder: round-robin arbitration between CPU and LCD masters,
// serving 4-beat x 16-bit bursts from on-chip video RAM.
module fml_vram_slave
    import fml_pkg::*;
#(
    parameter int fml_depth = 20,
    parameter int ram_aw    = 16
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,

    input  logic [fml_depth-1:0] cpu_fml_adr,
    input  logic                 cpu_fml_stb,
    input  logic                 cpu_fml_we,
    output logic                 cpu_fml_ack,
    input  logic [1:0]           cpu_fml_sel,
    input  logic [FML_DW-1:0]    cpu_fml_do,
    output logic [FML_DW-1:0]    cpu_fml_di,

    input  logic [fml_depth-1:0] lcd_fml_adr,
    input  logic                 lcd_fml_stb,
    input  logic                 lcd_fml_we,
    output logic                 lcd_fml_ack,
    input  logic [1:0]           lcd_fml_sel,
    input  logic [FML_DW-1:0]    lcd_fml_do,
    output logic [FML_DW-1:0]    lcd_fml_di
);

    localparam logic [FML_BEAT_BITS-1:0] LAST_BEAT = FML_BEAT_BITS'(FML_BURST_LEN - 1);

    fml_state_e               state_q, state_d;
    logic [FML_BEAT_BITS-1:0] beat_q, beat_d;
    logic                     grant_q, grant_d;
    logic [fml_depth-4:0]     base_q, base_d;
    logic                     we_q, we_d;

    logic                     ramEn;
    logic                     ramWe;
    logic [1:0]               ramBe;
    logic [ram_aw-1:0]        ramAddr;
    logic [FML_DW-1:0]        ramWdata;
    logic [FML_DW-1:0]        ramRdata;

    logic                     unusedAdrBits;
    assign unusedAdrBits = ^{cpu_fml_adr[2:0], lcd_fml_adr[2:0]};

    // grant_q doubles as last_grant: it keeps the most recent winner between bursts.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            grant_q <= PORT_CPU;
            base_q  <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            grant_q <= grant_d;
            base_q  <= base_d;
            we_q    <= we_d;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        grant_d = grant_q;
        base_d  = base_q;
        we_d    = we_q;
        case (state_q)
            ST_IDLE: begin
                beat_d = '0;
                if (cpu_fml_stb || lcd_fml_stb) begin
                    if (cpu_fml_stb && lcd_fml_stb) begin
                        grant_d = ~grant_q;
                    end else begin
                        grant_d = lcd_fml_stb ? PORT_LCD : PORT_CPU;
                    end
                    base_d  = (grant_d == PORT_LCD) ? lcd_fml_adr[fml_depth-1:3]
                                                    : cpu_fml_adr[fml_depth-1:3];
                    we_d    = (grant_d == PORT_LCD) ? lcd_fml_we : cpu_fml_we;
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                beat_d  = FML_BEAT_BITS'(1);
                state_d = ST_BURST;
            end
            ST_BURST: begin
                if (beat_q == LAST_BEAT) begin
                    beat_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    beat_d = beat_q + FML_BEAT_BITS'(1);
                end
            end
            default: begin
                beat_d  = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // beat_q is zero in ACK, so one RAM access per cycle covers beats 0..3.
    always_comb begin
        cpu_fml_ack = 1'b0;
        lcd_fml_ack = 1'b0;
        ramEn       = (state_q == ST_ACK) || (state_q == ST_BURST);
        ramWe       = ramEn && we_q;
        ramBe       = 2'b00;
        ramAddr     = ram_aw'({base_q, beat_q});
        ramWdata    = (grant_q == PORT_LCD) ? lcd_fml_do : cpu_fml_do;
        if (ramWe) begin
            ramBe = (grant_q == PORT_LCD) ? lcd_fml_sel : cpu_fml_sel;
        end
        if (state_q == ST_ACK) begin
            cpu_fml_ack = (grant_q == PORT_CPU);
            lcd_fml_ack = (grant_q == PORT_LCD);
        end
    end

    vram_spram #(
        .AW(ram_aw)
    ) uRam (
        .clk_i   (sys_clk),
        .rst_ni  (sys_rst_n),
        .en_i    (ramEn),
        .we_i    (ramWe),
        .be_i    (ramBe),
        .addr_i  (ramAddr),
        .wdata_i (ramWdata),
        .rdata_o (ramRdata)
    );

    assign cpu_fml_di = ramRdata;
    assign lcd_fml_di = ramRdata;

endmodule

// File: tb/tb_fml_vram_slave.sv
// Directed bench for fml_vram_slave: reset, round-robin arbitration, write/read bursts,
// byte masks, address aliasing and reset in the middle of a write burst.
module tb_fml_vram_slave;
    import fml_pkg::*;

    logic        sys_clk;
    logic        sys_rst_n;
    logic [19:0] cpu_fml_adr;
    logic        cpu_fml_stb;
    logic        cpu_fml_we;
    logic        cpu_fml_ack;
    logic [1:0]  cpu_fml_sel;
    logic [15:0] cpu_fml_do;
    logic [15:0] cpu_fml_di;
    logic [19:0] lcd_fml_adr;
    logic        lcd_fml_stb;
    logic        lcd_fml_we;
    logic        lcd_fml_ack;
    logic [1:0]  lcd_fml_sel;
    logic [15:0] lcd_fml_do;
    logic [15:0] lcd_fml_di;

    int checks = 0;
    int errors = 0;

    fml_vram_slave #(
        .fml_depth(20),
        .ram_aw   (16)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .cpu_fml_adr (cpu_fml_adr),
        .cpu_fml_stb (cpu_fml_stb),
        .cpu_fml_we  (cpu_fml_we),
        .cpu_fml_ack (cpu_fml_ack),
        .cpu_fml_sel (cpu_fml_sel),
        .cpu_fml_do  (cpu_fml_do),
        .cpu_fml_di  (cpu_fml_di),
        .lcd_fml_adr (lcd_fml_adr),
        .lcd_fml_stb (lcd_fml_stb),
        .lcd_fml_we  (lcd_fml_we),
        .lcd_fml_ack (lcd_fml_ack),
        .lcd_fml_sel (lcd_fml_sel),
        .lcd_fml_do  (lcd_fml_do),
        .lcd_fml_di  (lcd_fml_di)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Every comparison funnels through here so the counters stay in one place.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic setPort(input logic port, input logic stb, input logic we, input logic [19:0] adr,
                           input logic [15:0] data, input logic [1:0] sel);
        if (port == PORT_LCD) begin
            lcd_fml_stb = stb; lcd_fml_we = we; lcd_fml_adr = adr; lcd_fml_do = data; lcd_fml_sel = sel;
        end else begin
            cpu_fml_stb = stb; cpu_fml_we = we; cpu_fml_adr = adr; cpu_fml_do = data; cpu_fml_sel = sel;
        end
    endtask

    // One complete burst on one port; beat 0 sits in the top 16 bits of wdata/rdata.
    task automatic applyStimulus(input logic port, input logic we, input logic [19:0] adr,
                                 input logic [63:0] wdata, input logic [7:0] wsel,
                                 output logic [63:0] rdata, output int lat);
        logic got;
        got   = 1'b0;
        lat   = -1;
        rdata = '0;
        @(posedge sys_clk); #1;
        setPort(port, 1'b1, we, adr, wdata[63:48], wsel[7:6]);
        for (int i = 0; i < 16; i++) begin
            @(negedge sys_clk);
            if ((port == PORT_LCD) ? lcd_fml_ack : cpu_fml_ack) begin
                got = 1'b1;
                lat = i;
                break;
            end
        end
        checkOutput("ack latency", 32'(lat), 32'd1);
        if (!got) begin
            setPort(port, 1'b0, 1'b0, adr, 16'h0, 2'b00);
            return;
        end
        for (int k = 0; k < 4; k++) begin
            @(posedge sys_clk); #1;
            if (k < 3) begin
                setPort(port, 1'b0, we, adr, wdata[47-16*k -: 16], wsel[5-2*k -: 2]);
            end else begin
                setPort(port, 1'b0, 1'b0, adr, 16'h0, 2'b00);
            end
            @(negedge sys_clk);
            rdata[63-16*k -: 16] = (port == PORT_LCD) ? lcd_fml_di : cpu_fml_di;
        end
    endtask

    task automatic checkBurst(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("%s beat%0d", tag, k),
                        32'(observed[63-16*k -: 16]), 32'(expected[63-16*k -: 16]));
        end
    endtask

    initial begin
        logic [63:0] rd;
        int lat;
        logic got;

        sys_rst_n = 1'b0;
        setPort(PORT_CPU, 1'b1, 1'b0, 20'h0, 16'h0, 2'b00);
        setPort(PORT_LCD, 1'b1, 1'b0, 20'h0, 16'h0, 2'b00);

        // Both masters request from reset: outputs must stay quiet while held.
        for (int i = 0; i < 3; i++) begin
            @(negedge sys_clk);
            checkOutput("reset cpu_ack", 32'(cpu_fml_ack), 32'd0);
            checkOutput("reset lcd_ack", 32'(lcd_fml_ack), 32'd0);
            checkOutput("reset cpu_di", 32'(cpu_fml_di), 32'h0);
            checkOutput("reset lcd_di", 32'(lcd_fml_di), 32'h0);
        end
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b1;

        // Round robin from last_grant=CPU: LCD, CPU, LCD, CPU five cycles apart.
        for (int i = 0; i < 19; i++) begin
            @(negedge sys_clk);
            checkOutput($sformatf("rr cpu_ack c%0d", i), 32'(cpu_fml_ack), 32'((i == 6) || (i == 16)));
            checkOutput($sformatf("rr lcd_ack c%0d", i), 32'(lcd_fml_ack), 32'((i == 1) || (i == 11)));
        end
        @(posedge sys_clk); #1;
        cpu_fml_stb = 1'b0;
        lcd_fml_stb = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge sys_clk);
            checkOutput("drain no ack", 32'({cpu_fml_ack, lcd_fml_ack}), 32'd0);
        end

        applyStimulus(PORT_CPU, 1'b1, 20'h00108, 64'h1111_2222_3333_4444, 8'hFF, rd, lat);
        applyStimulus(PORT_CPU, 1'b0, 20'h0010F, 64'h0, 8'h00, rd, lat);
        checkBurst("cpu readback", rd, 64'h1111_2222_3333_4444);

        applyStimulus(PORT_CPU, 1'b1, 20'h00200, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, rd, lat);
        applyStimulus(PORT_LCD, 1'b1, 20'h00200, 64'h0, 8'b10_01_00_11, rd, lat);
        applyStimulus(PORT_LCD, 1'b0, 20'h00200, 64'h0, 8'h00, rd, lat);
        checkBurst("byte mask", rd, 64'h00FF_FF00_FFFF_0000);

        applyStimulus(PORT_LCD, 1'b1, 20'h20000, 64'hABCD_ABCD_ABCD_ABCD, 8'hFF, rd, lat);
        applyStimulus(PORT_CPU, 1'b0, 20'h00000, 64'h0, 8'h00, rd, lat);
        checkBurst("alias", rd, 64'hABCD_ABCD_ABCD_ABCD);

        applyStimulus(PORT_CPU, 1'b1, 20'h00300, 64'h5001_5002_5003_5004, 8'hFF, rd, lat);

        // Write burst interrupted by reset right after beat 1 has been written.
        @(posedge sys_clk); #1;
        setPort(PORT_CPU, 1'b1, 1'b1, 20'h00300, 16'hA001, 2'b11);
        got = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge sys_clk);
            if (cpu_fml_ack) begin
                got = 1'b1;
                break;
            end
        end
        checkOutput("abort ack seen", 32'(got), 32'd1);
        @(posedge sys_clk); #1;
        setPort(PORT_CPU, 1'b0, 1'b1, 20'h00300, 16'hA002, 2'b11);
        @(posedge sys_clk); #1;
        setPort(PORT_CPU, 1'b0, 1'b1, 20'h00300, 16'hA003, 2'b11);
        sys_rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge sys_clk);
            checkOutput("abort rst acks", 32'({cpu_fml_ack, lcd_fml_ack}), 32'd0);
            checkOutput("abort rst di", 32'(cpu_fml_di), 32'h0);
        end
        @(posedge sys_clk); #1;
        setPort(PORT_CPU, 1'b0, 1'b0, 20'h00300, 16'hA004, 2'b11);
        sys_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge sys_clk);
            checkOutput("post abort no ack", 32'({cpu_fml_ack, lcd_fml_ack}), 32'd0);
        end
        applyStimulus(PORT_LCD, 1'b0, 20'h00300, 64'h0, 8'h00, rd, lat);
        checkBurst("abort readback", rd, 64'hA001_A002_5003_5004);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
